// File: rtl/rr_merge.sv
// Round-robin merge of N native-bus masters onto one downstream port.
// One transaction in flight at a time; the payload is passed through, never stored.
module rr_merge #(
    parameter int N_MASTERS = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    localparam int REQ_W    = 1 + ADDR_W + DATA_W + DATA_W / 8,
    localparam int RESP_W   = DATA_W + 1,
    localparam int GW       = $clog2(N_MASTERS)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_MASTERS*REQ_W-1:0]    m_req,
    output logic [N_MASTERS*RESP_W-1:0]   m_resp,
    output logic [REQ_W-1:0]              s_req,
    input  logic [RESP_W-1:0]             s_resp,
    output logic                          o_dbg_state
);

    // Handshake: a master raises valid with a stable payload and holds both
    // until it sees ready=1 on its response slice; ready is a one-cycle strobe.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [GW-1:0]       r_gnt;
    logic [GW-1:0]       r_lst;
    logic [GW-1:0]       w_gnt_nxt;
    logic [GW-1:0]       w_lst_nxt;
    logic [GW-1:0]       w_pick;
    logic                w_found;
    logic [N_MASTERS-1:0] w_valid;
    int                  w_dist;
    int                  w_best;

    always_comb begin
        w_valid = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            w_valid[i] = m_req[i*REQ_W + REQ_W - 1];
        end
    end

    // Distance of master i after the last-served one; the smallest wins.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_best  = N_MASTERS;
        w_dist  = 0;
        for (int i = 0; i < N_MASTERS; i++) begin
            w_dist = (i + 2 * N_MASTERS - int'(r_lst) - 1) % N_MASTERS;
            if (w_valid[i] && (w_dist < w_best)) begin
                w_best  = w_dist;
                w_pick  = GW'(i);
                w_found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_gnt   <= '0;
            r_lst   <= GW'(N_MASTERS - 1);
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_lst   <= w_lst_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_lst_nxt   = r_lst;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_gnt_nxt   = w_pick;
                    w_state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (s_resp[0]) begin
                    w_lst_nxt   = r_gnt;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Downstream ready seen in IDLE reaches nobody.
    always_comb begin
        s_req  = '0;
        m_resp = '0;
        if (r_state == ST_BUSY) begin
            for (int i = 0; i < N_MASTERS; i++) begin
                if (GW'(i) == r_gnt) begin
                    s_req                        = m_req[i*REQ_W +: REQ_W];
                    m_resp[i*RESP_W +: RESP_W]   = s_resp;
                end
            end
        end
    end

    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_rr_merge.sv
// Bench for rr_merge with three masters: vector table of first grants, directed
// corner sequences, then random traffic against a rotation-list reference model.
module tb_rr_merge;

    localparam int N      = 3;
    localparam int AW     = 32;
    localparam int DW     = 32;
    localparam int REQ_W  = 1 + AW + DW + DW / 8;
    localparam int RESP_W = DW + 1;

    logic                  clk;
    logic                  rst;
    logic [N*REQ_W-1:0]    m_req;
    logic [N*RESP_W-1:0]   m_resp;
    logic [REQ_W-1:0]      s_req;
    logic [RESP_W-1:0]     s_resp;
    logic                  dbg_state;

    logic                  mv [N];
    logic [AW-1:0]         ma [N];
    logic [DW-1:0]         md [N];
    logic [DW/8-1:0]       ms [N];
    logic                  s_rdy;
    logic [DW-1:0]         s_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    logic [1:0] exp_q[$];

    typedef struct {
        logic [N-1:0] mask;
        int           exp_gnt;
    } arb_vec_t;

    rr_merge #(.N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .m_req       (m_req),
        .m_resp      (m_resp),
        .s_req       (s_req),
        .s_resp      (s_resp),
        .o_dbg_state (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded its time budget");
        $fatal(1, "timeout");
    end

    always_comb begin
        m_req = '0;
        for (int i = 0; i < N; i++) begin
            m_req[i*REQ_W +: REQ_W] = {mv[i], ma[i], md[i], ms[i]};
        end
    end
    assign s_resp = {s_rdata, s_rdy};

    // scoreboard helpers
    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [REQ_W-1:0] exp_req(input int i);
        return {mv[i], ma[i], md[i], ms[i]};
    endfunction

    function automatic logic [N*RESP_W-1:0] exp_resp(input int g, input logic [RESP_W-1:0] r);
        logic [N*RESP_W-1:0] v;
        v = '0;
        v[g*RESP_W +: RESP_W] = r;
        return v;
    endfunction

    // driver tasks
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_masters();
        for (int i = 0; i < N; i++) begin
            mv[i] = 1'b0;
            ma[i] = '0;
            md[i] = '0;
            ms[i] = '0;
        end
    endtask

    task automatic set_master(input int i, input logic [AW-1:0] a, input logic [DW/8-1:0] st);
        mv[i] = 1'b1;
        ma[i] = a;
        md[i] = $urandom;
        ms[i] = st;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        clear_masters();
        s_rdy   = 1'b0;
        s_rdata = '0;
        #1;
        check("rst_s_req", s_req, '0);
        check("rst_m_resp", m_resp, '0);
        check("rst_state", dbg_state, 1'b0);
        cyc();
        cyc();
        rst = 1'b1;
    endtask

    // Called in an IDLE cycle right after the masters were driven.
    task automatic serve_one(input int g, input bit drop);
        logic [RESP_W-1:0] r;
        #2;
        check("arb_idle_valid", s_req[REQ_W-1], 1'b0);
        check("arb_idle_ready", m_resp, '0);
        cyc();
        check("serve_s_req", s_req, exp_req(g));
        check("serve_state", dbg_state, 1'b1);
        s_rdy   = 1'b1;
        s_rdata = $urandom;
        r       = {s_rdata, 1'b1};
        #1;
        check("serve_m_resp", m_resp, exp_resp(g, r));
        cyc();
        s_rdy = 1'b0;
        if (drop) mv[g] = 1'b0;
    endtask

    initial begin
        arb_vec_t  vecs[7];
        int        order[$];
        int        ord4[4];
        bit        m_busy;
        int        owner;
        bit        served[N];
        logic [1:0] seen;

        rst = 1'b0;
        clear_masters();
        s_rdy   = 1'b0;
        s_rdata = '0;

        // first grant after reset is the lowest-indexed valid master
        vecs[0] = '{3'b001, 0};
        vecs[1] = '{3'b010, 1};
        vecs[2] = '{3'b100, 2};
        vecs[3] = '{3'b011, 0};
        vecs[4] = '{3'b110, 1};
        vecs[5] = '{3'b111, 0};
        vecs[6] = '{3'b101, 0};
        for (int v = 0; v < 7; v++) begin
            do_reset();
            for (int i = 0; i < N; i++) begin
                if (vecs[v].mask[i]) set_master(i, 32'h1000 + 32'(i * 16), (i == 1) ? 4'hF : 4'h0);
            end
            serve_one(vecs[v].exp_gnt, 1'b1);
            clear_masters();
        end

        // single master read: latency, rdata delivery, other master quiet
        do_reset();
        set_master(0, 32'h100, 4'h0);
        #2;
        check("single_idle_valid", s_req[REQ_W-1], 1'b0);
        cyc();
        check("single_s_req", s_req, exp_req(0));
        for (int k = 0; k < 3; k++) begin
            check("single_wait_resp", m_resp, '0);
            cyc();
        end
        s_rdy   = 1'b1;
        s_rdata = 32'hDEADBEEF;
        #1;
        check("single_m0_resp", m_resp[0 +: RESP_W], {32'hDEADBEEF, 1'b1});
        check("single_m1_ready", m_resp[RESP_W], 1'b0);
        cyc();
        s_rdy = 1'b0;
        mv[0] = 1'b0;
        #1;
        check("single_after_valid", s_req[REQ_W-1], 1'b0);

        // contention m0/m1 (m1 writes): 0,1,0,1
        do_reset();
        set_master(0, 32'h200, 4'h0);
        set_master(1, 32'h300, 4'hF);
        ord4 = '{0, 1, 0, 1};
        for (int t = 0; t < 4; t++) serve_one(ord4[t], 1'b0);
        clear_masters();

        // wrap-around with all three valid: 0,1,2,0
        do_reset();
        for (int i = 0; i < N; i++) set_master(i, 32'h400 + 32'(i), 4'(i));
        ord4 = '{0, 1, 2, 0};
        for (int t = 0; t < 4; t++) serve_one(ord4[t], 1'b0);
        clear_masters();

        // stall with m1 granted and m0 waiting
        do_reset();
        set_master(1, 32'h2000, 4'h3);
        #2;
        cyc();
        set_master(0, 32'h2100, 4'h0);
        for (int k = 0; k < 20; k++) begin
            s_rdata = $urandom;
            #1;
            check("stall_s_req", s_req, exp_req(1));
            check("stall_m_resp", m_resp, exp_resp(1, {s_rdata, 1'b0}));
            cyc();
        end
        s_rdy = 1'b1;
        #1;
        check("stall_m1_ready", m_resp, exp_resp(1, {s_rdata, 1'b1}));
        cyc();
        s_rdy = 1'b0;
        mv[1] = 1'b0;
        serve_one(0, 1'b1);

        // reset while m1 is being served
        do_reset();
        set_master(1, 32'h3000, 4'h0);
        #2;
        cyc();
        check("rstbusy_s_req", s_req, exp_req(1));
        set_master(0, 32'h3100, 4'h0);
        s_rdy = 1'b1;
        rst   = 1'b0;
        #1;
        check("rstbusy_async_s_req", s_req, '0);
        check("rstbusy_async_m_resp", m_resp, '0);
        cyc();
        cyc();
        s_rdy = 1'b0;
        rst   = 1'b1;
        serve_one(0, 1'b1);
        clear_masters();

        // spurious downstream ready while idle
        do_reset();
        s_rdy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            s_rdata = $urandom;
            #1;
            check("spur_m_resp", m_resp, '0);
            check("spur_s_req", s_req, '0);
            check("spur_state", dbg_state, 1'b0);
            cyc();
        end
        s_rdy = 1'b0;

        // random traffic against the rotation-list model
        do_reset();
        order  = '{0, 1, 2};
        m_busy = 1'b0;
        owner  = 0;
        for (int i = 0; i < N; i++) served[i] = 1'b0;
        for (int c = 0; c < 400; c++) begin
            cyc();
            for (int i = 0; i < N; i++) begin
                if (served[i]) begin
                    mv[i]     = 1'b0;
                    served[i] = 1'b0;
                end else if (!mv[i] && ($urandom_range(0, 2) == 0)) begin
                    set_master(i, $urandom, 4'($urandom_range(0, 15)));
                end
            end
            s_rdy   = ($urandom_range(0, 2) == 0);
            s_rdata = $urandom;
            #2;
            check("rnd_state", dbg_state, m_busy);
            check("rnd_s_req", s_req, m_busy ? exp_req(owner) : '0);
            check("rnd_m_resp", m_resp, m_busy ? exp_resp(owner, {s_rdata, s_rdy}) : '0);
            if (m_busy && s_rdy) begin
                seen = 2'd3;
                for (int i = 0; i < N; i++) if (m_resp[i*RESP_W]) seen = 2'(i);
                check("rnd_order", seen, exp_q.pop_front());
                served[owner] = 1'b1;
                while (order[$] != owner) order.push_back(order.pop_front());
                m_busy = 1'b0;
            end else if (!m_busy) begin
                foreach (order[k]) begin
                    if (!m_busy && mv[order[k]]) begin
                        owner  = order[k];
                        m_busy = 1'b1;
                        exp_q.push_back(2'(owner));
                    end
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
